// File: rtl/key_step_conditioner_pkg.sv
// key_step_conditioner_pkg: detector FSM state encodings and board-level defaults
package key_step_conditioner_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PRESS_CHK, S_HELD, S_REL_CHK} state_t;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
endpackage

// File: rtl/key_step_conditioner_sync_ff.sv
// sync_ff: STAGES-deep flip-flop synchroniser with configurable reset value
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic aclr,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk or negedge aclr)
    if (!aclr) r <= {STAGES{RST_VAL}};
    else       r <= {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/key_step_conditioner.sv
// key_step_conditioner: sync + debounce KEY into a step pulse, sample SW into w_out; KEY_AUTOREPEAT_EN adds held-key repeat
module key_step_conditioner
  import key_step_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       key_n,
  input  logic       w_raw,
  output logic       step,
  output logic       w_out,
  output logic       key_level,
  output logic [7:0] step_cnt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic key_s, kp, ws, press_step, fire, step_d;
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_key_sync (.clk(clk), .aclr(aclr), .d(key_n), .q(key_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_w_sync   (.clk(clk), .aclr(aclr), .d(w_raw), .q(ws));
  assign kp = ~key_s;
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_step = 1'b0;
    case (state)
      S_IDLE:
        if (kp) begin
          state_nx = S_PRESS_CHK;
          cnt_nx   = '0;
        end
      S_PRESS_CHK:
        if (!kp) state_nx = S_IDLE;
        else if (cnt == CMAX) begin
          state_nx   = S_HELD;
          press_step = 1'b1;
        end else cnt_nx = cnt + 1'b1;
      S_HELD:
        if (!kp) begin
          state_nx = S_REL_CHK;
          cnt_nx   = '0;
        end
      S_REL_CHK:
        if (kp) state_nx = S_HELD;
        else if (cnt == CMAX) state_nx = S_IDLE;
        else cnt_nx = cnt + 1'b1;
      default: state_nx = S_IDLE;
    endcase
  end
`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic [RW-1:0] rcnt;
  logic rep, run;
  assign run  = state == S_HELD && kp;
  assign fire = run && rcnt == (rep ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
  always_ff @(posedge clk or negedge aclr)
    if (!aclr) begin
      rcnt <= '0;
      rep  <= 1'b0;
    end else if (!run) begin
      rcnt <= '0;
      rep  <= 1'b0;
    end else if (fire) begin
      rcnt <= '0;
      rep  <= 1'b1;
    end else rcnt <= rcnt + 1'b1;
`else
  // repeat timing only matters with auto-repeat; this folds to constant 0
  assign fire = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif
  assign step_d = press_step | fire;
  always_ff @(posedge clk or negedge aclr)
    if (!aclr) begin
      state    <= S_IDLE;
      cnt      <= '0;
      step     <= 1'b0;
      w_out    <= 1'b0;
      step_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      step  <= step_d;
      if (step_d) begin
        w_out    <= ws;
        step_cnt <= step_cnt + 1'b1;
      end
    end
  assign key_level = state == S_HELD || state == S_REL_CHK;
endmodule

// File: tb/tb_key_step_conditioner.sv
// tb_key_step_conditioner: directed checks of debounce latency, bounce rejection, w capture, step_cnt wrap, auto-repeat
module tb_key_step_conditioner;
  logic clk = 1'b0, aclr = 1'b0, key_n = 1'b0, w_raw = 1'b0;
  logic step, w_out, key_level;
  logic [7:0] step_cnt;
  int total = 0, passed = 0, ec = 0, base = 0, kl_drop = 0;
  bit watch = 1'b0;
  int stamps[$];
  int exp_q[$];

  key_step_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(20), .REPEAT_PERIOD(6)) dut (
    .clk(clk), .aclr(aclr), .key_n(key_n), .w_raw(w_raw),
    .step(step), .w_out(w_out), .key_level(key_level), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (step) stamps.push_back(ec);
    if (watch && !key_level) kl_drop++;
    ec++;
  end

  task check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int offs(input int i);
    return stamps.size() > i ? stamps[i] - base : -1;
  endfunction

  task drive(input logic kn, input int n);
    key_n = kn;
    repeat (n) @(negedge clk);
  endtask

  task mark;
    stamps.delete();
    base = ec;
  endtask

  task do_reset;
    aclr  = 1'b0;
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    aclr = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_step", step, 0);
    check("rst_w_out", w_out, 0);
    check("rst_key_level", key_level, 0);
    check("rst_step_cnt", step_cnt, 0);
    mark();
    aclr = 1'b1;
    drive(1'b0, 20);
    check("t1_steps", stamps.size(), 1);
    check("t1_latency", offs(0), 10);
    check("t1_step_cnt", step_cnt, 1);
    check("t1_key_level", key_level, 1);
    drive(1'b1, 20);
    check("t1_released", key_level, 0);

    do_reset();
    w_raw = 1'b1;
    drive(1'b1, 4);
    mark();
    drive(1'b0, 20);
    drive(1'b1, 20);
    check("t2_steps", stamps.size(), 1);
    check("t2_latency", offs(0), 10);
    check("t2_w_out", w_out, 1);
    check("t2_step_cnt", step_cnt, 1);

    do_reset();
    w_raw = 1'b0;
    drive(1'b1, 4);
    mark();
    drive(1'b0, 5);
    drive(1'b1, 2);
    base = ec;
    drive(1'b0, 20);
    drive(1'b1, 20);
    check("t3_steps", stamps.size(), 1);
    check("t3_latency", offs(0), 10);
    check("t3_w_out", w_out, 0);

    do_reset();
    mark();
    drive(1'b0, 20);
    watch = 1'b1;
    drive(1'b1, 3);
    drive(1'b0, 15);
    watch = 1'b0;
    check("t4_level_drop", kl_drop, 0);
    check("t4_steps", stamps.size(), 1);
    drive(1'b1, 14);
    check("t4_released", key_level, 0);

    do_reset();
    mark();
    for (int i = 0; i < 256; i++) begin
      w_raw = ~w_raw;
      drive(1'b1, 2);
      drive(1'b0, 12);
      check($sformatf("t5_w_out_%0d", i), w_out, w_raw);
      if (i == 254) check("t5_cnt_255", step_cnt, 255);
      drive(1'b1, 12);
    end
    check("t5_steps", stamps.size(), 256);
    check("t5_wrap", step_cnt, 0);

    do_reset();
    mark();
    drive(1'b0, 50);
    drive(1'b1, 20);
`ifdef KEY_AUTOREPEAT_EN
    exp_q = '{10, 30, 36, 42, 48};
`else
    exp_q = '{10};
`endif
    check("t6_steps", stamps.size(), exp_q.size());
    foreach (exp_q[i]) check($sformatf("t6_step_%0d", i), offs(i), exp_q[i]);
    check("t6_step_cnt", step_cnt, exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
